// File: rtl/debayer_line_window_pkg.sv
// Shared constants for the Bayer line-window path: line-count width and saturation.
package debayer_line_window_pkg;
  localparam int unsigned LCNT_W = 2;
  localparam logic [LCNT_W-1:0] LCNT_SAT = LCNT_W'(2);
endpackage

// File: rtl/debayer_line_window_ram.sv
// Simple dual-port line RAM: write port A, registered read-first read port B.
module debayer_line_window_ram #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read sees pre-write contents on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/debayer_line_window.sv
// Two-row line-buffer controller emitting a vertically aligned 3-pixel column per input pixel.
module debayer_line_window
  import debayer_line_window_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sol,
  input  logic              in_sof,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_p0,
  output logic [DATA_W-1:0] out_p1,
  output logic [DATA_W-1:0] out_p2,
  output logic [ADDR_W-1:0] out_col,
  output logic              out_sol,
  output logic              out_sof,
  output logic              out_p1_ok,
  output logic              out_p2_ok,
  output logic              out_ovf
);
  localparam logic [ADDR_W-1:0] COL_MAX = '1;

  logic [ADDR_W-1:0] col_next;
  logic              col_full;
  logic [LCNT_W-1:0] lcnt;
  logic              wr2_pend;

  logic              first_c;
  logic [ADDR_W-1:0] addr_c;
  logic [ADDR_W-1:0] col_next_c;
  logic [LCNT_W-1:0] lcnt_c;
  logic              ovf_c;

  // Column/line bookkeeping for the pixel currently offered.
  always_comb begin
    first_c    = in_sol | in_sof;
    addr_c     = first_c ? '0 : col_next;
    col_next_c = (addr_c == COL_MAX) ? COL_MAX : addr_c + ADDR_W'(1);
    lcnt_c     = lcnt;
    ovf_c      = out_ovf;
    if (in_sof) begin
      lcnt_c = '0;
    end else if (in_sol && (lcnt != LCNT_SAT)) begin
      lcnt_c = lcnt + LCNT_W'(1);
    end
    // Overflow only once the last column was already consumed by this line.
    if (in_sof) begin
      ovf_c = 1'b0;
    end else if (!in_sol && col_full) begin
      ovf_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_next  <= '0;
      col_full  <= 1'b0;
      lcnt      <= '0;
      wr2_pend  <= 1'b0;
      out_valid <= 1'b0;
      out_p0    <= '0;
      out_col   <= '0;
      out_sol   <= 1'b0;
      out_sof   <= 1'b0;
      out_p1_ok <= 1'b0;
      out_p2_ok <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      wr2_pend  <= in_valid;
      if (in_valid) begin
        col_next  <= col_next_c;
        col_full  <= (addr_c == COL_MAX);
        lcnt      <= lcnt_c;
        out_p0    <= in_data;
        out_col   <= addr_c;
        out_sol   <= in_sol;
        out_sof   <= in_sof;
        out_p1_ok <= (lcnt_c >= LCNT_W'(1));
        out_p2_ok <= (lcnt_c >= LCNT_SAT);
        out_ovf   <= ovf_c;
      end
    end
  end

  debayer_line_window_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram1 (
    .clk  (clk),
    .rst  (rst),
    .we   (in_valid),
    .waddr(addr_c),
    .wdata(in_data),
    .re   (in_valid),
    .raddr(addr_c),
    .rdata(out_p1)
  );

  // Row-1 data read last cycle cascades into row-2 at the same column.
  debayer_line_window_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram2 (
    .clk  (clk),
    .rst  (rst),
    .we   (wr2_pend),
    .waddr(out_col),
    .wdata(out_p1),
    .re   (in_valid),
    .raddr(addr_c),
    .rdata(out_p2)
  );
endmodule

// File: tb/tb_debayer_line_window.sv
// Scoreboard bench for debayer_line_window (ADDR_W=2 so overflow is reachable).
module tb_debayer_line_window;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned ADDR_W = 2;
  localparam int LAT = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_sol;
  logic              in_sof;
  logic              out_valid;
  logic [DATA_W-1:0] out_p0, out_p1, out_p2;
  logic [ADDR_W-1:0] out_col;
  logic              out_sol, out_sof, out_p1_ok, out_p2_ok, out_ovf;

  typedef struct {
    int  p0, p1, p2, col;
    bit  sol, sof, ok1, ok2, ovf;
    time stamp;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  debayer_line_window #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_sol(in_sol), .in_sof(in_sof), .out_valid(out_valid),
    .out_p0(out_p0), .out_p1(out_p1), .out_p2(out_p2), .out_col(out_col),
    .out_sol(out_sol), .out_sof(out_sof), .out_p1_ok(out_p1_ok),
    .out_p2_ok(out_p2_ok), .out_ovf(out_ovf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.p0 = 0; e.p1 = 0; e.p2 = 0; e.col = 0;
    e.sol = 0; e.sof = 0; e.ok1 = 0; e.ok2 = 0; e.ovf = 0; e.stamp = 0;
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e, input bit chk_lat);
    chk({tag, ".p0"}, int'(out_p0), e.p0);
    if (e.p1 >= 0) chk({tag, ".p1"}, int'(out_p1), e.p1);
    if (e.p2 >= 0) chk({tag, ".p2"}, int'(out_p2), e.p2);
    chk({tag, ".col"}, int'(out_col), e.col);
    chk({tag, ".sol"}, int'(out_sol), int'(e.sol));
    chk({tag, ".sof"}, int'(out_sof), int'(e.sof));
    chk({tag, ".p1_ok"}, int'(out_p1_ok), int'(e.ok1));
    chk({tag, ".p2_ok"}, int'(out_p2_ok), int'(e.ok2));
    chk({tag, ".ovf"}, int'(out_ovf), int'(e.ovf));
    if (chk_lat) chk({tag, ".latency"}, int'($time - e.stamp), LAT);
  endtask

  // Monitor: pop on every valid output, otherwise verify outputs hold.
  always @(negedge clk) begin
    if (rst) begin
      last = zero_exp();
    end else if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at %0t: got out_valid=1 expected no output", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp_out("out", e, 1'b1);
        last = e;
      end
    end else begin
      cmp_out("hold", last, 1'b0);
    end
  end

  task automatic px(input int d, input bit sol, input bit sof, input int col,
                    input int p1, input int p2, input bit ok1, input bit ok2, input bit ovf);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    in_sol   = sol;
    in_sof   = sof;
    e.p0 = d; e.p1 = p1; e.p2 = p2; e.col = col;
    e.sol = sol; e.sof = sof; e.ok1 = ok1; e.ok2 = ok2; e.ovf = ovf;
    e.stamp = $time;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = DATA_W'($urandom_range(0, 1023));
      in_sol   = 1'($urandom_range(0, 1));
      in_sof   = 1'($urandom_range(0, 1));
    end
  endtask

  // Four-pixel line; p1b/p2b < 0 means that row is not compared.
  task automatic line4(input int base, input bit sof, input int p1b, input int p2b,
                       input bit ok1, input bit ok2, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps && i > 0) idle((i % 3) + 1);
      px(base + i, i == 0, sof && (i == 0), i,
         (p1b < 0) ? -1 : p1b + i, (p2b < 0) ? -1 : p2b + i, ok1, ok2, 1'b0);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp_out(tag, zero_exp(), 1'b0);
    chk({tag, ".valid"}, int'(out_valid), 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #2;
    check_zero("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sol = 1'b0; in_sof = 1'b0;
    #3;
    check_zero("rst0");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Gap-free frame of three lines.
    line4(1,  1'b1, -1, -1, 1'b0, 1'b0, 1'b0);
    line4(11, 1'b0,  1, -1, 1'b1, 1'b0, 1'b0);
    line4(21, 1'b0, 11,  1, 1'b1, 1'b1, 1'b0);

    // New frame with valid gaps; old RAM data must be masked on its first line.
    idle(2);
    line4(101, 1'b1,  -1,  -1, 1'b0, 1'b0, 1'b1);
    idle(1);
    line4(111, 1'b0, 101,  -1, 1'b1, 1'b0, 1'b1);
    line4(121, 1'b0, 111, 101, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of line 2.
    px(5,  1'b1, 1'b1, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    px(6,  1'b0, 1'b0, 1, -1, -1, 1'b0, 1'b0, 1'b0);
    px(15, 1'b1, 1'b0, 0,  5, -1, 1'b1, 1'b0, 1'b0);
    idle(1);
    reset_pulse();
    px(40, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    px(41, 1'b0, 1'b0, 1, -1, -1, 1'b0, 1'b0, 1'b0);
    px(50, 1'b1, 1'b0, 0, 40, -1, 1'b1, 1'b0, 1'b0);
    px(51, 1'b0, 1'b0, 1, 41, -1, 1'b1, 1'b0, 1'b0);

    // Six-pixel line against a 4-column RAM.
    px(60, 1'b1, 1'b1, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    px(61, 1'b0, 1'b0, 1, -1, -1, 1'b0, 1'b0, 1'b0);
    px(62, 1'b0, 1'b0, 2, -1, -1, 1'b0, 1'b0, 1'b0);
    px(63, 1'b0, 1'b0, 3, -1, -1, 1'b0, 1'b0, 1'b0);
    px(64, 1'b0, 1'b0, 3, -1, -1, 1'b0, 1'b0, 1'b1);
    px(65, 1'b0, 1'b0, 3, -1, -1, 1'b0, 1'b0, 1'b1);
    px(70, 1'b1, 1'b0, 0, 60, -1, 1'b1, 1'b0, 1'b1);
    px(71, 1'b0, 1'b0, 1, 61, -1, 1'b1, 1'b0, 1'b1);
    px(72, 1'b0, 1'b0, 2, 62, -1, 1'b1, 1'b0, 1'b1);
    px(73, 1'b0, 1'b0, 3, 65, -1, 1'b1, 1'b0, 1'b1);
    px(80, 1'b1, 1'b1, 0, -1, -1, 1'b0, 1'b0, 1'b0);

    // Single-pixel lines on consecutive cycles.
    idle(1);
    px(90, 1'b1, 1'b1, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    px(91, 1'b1, 1'b0, 0, 90, -1, 1'b1, 1'b0, 1'b0);
    px(92, 1'b1, 1'b0, 0, 91, -1, 1'b1, 1'b1, 1'b0);
    px(93, 1'b1, 1'b0, 0, 92, -1, 1'b1, 1'b1, 1'b0);
    px(94, 1'b1, 1'b0, 0, 93, -1, 1'b1, 1'b1, 1'b0);
    idle(3);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
